// File: rtl/ps2_frame_rx_pkg.sv
// Shared definitions for the PS/2 frame receiver: FSM state encoding,
// frame geometry and the odd-parity helper.
// No ports; imported by ps2_frame_rx.
package ps2_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int PS2_DATA_BITS = 8;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic pbit);
    return ^{data, pbit};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser, glitch filter and falling-edge strobe for one asynchronous PS/2 line.
// Ports: clk, reset (async active-low), raw (pin), level (filtered line), fall (1-cycle 1->0 strobe).
// Latency: raw change reaches level/fall after 2 sync flops plus FILTER_LEN samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synced samples that disagree with level; any
  // agreeing sample restarts it, so pulses shorter than FILTER_LEN vanish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= level;  // level is about to go 1->0 only if it is 1 now
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: one byte per valid frame, error pulse otherwise.
// Ports: clk, reset (async active-low), ps2Clk/ps2Data (raw pins),
//        scanDone/scanCode (new byte), frameErr (frame dropped), busy (frame in progress).
module ps2_frame_rx
  import ps2_frame_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000,
  parameter int TO_W        = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2Clk,
  input  logic                     ps2Data,
  output logic                     scanDone,
  output logic [PS2_DATA_BITS-1:0] scanCode,
  output logic                     frameErr,
  output logic                     busy
);

  localparam int BW = $clog2(PS2_DATA_BITS);

  logic                     clk_level_unused;
  logic                     fall;
  logic [1:0]               dsync;
  logic                     data;
  state_t                   state, state_nxt;
  logic [BW-1:0]            bitcnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     pbit;
  logic [TO_W-1:0]          tocnt;
  logic                     timeout;
  logic                     done_nxt, err_nxt, shift_en, pbit_en, start_en;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2Clk),
    .level (clk_level_unused),
    .fall  (fall)
  );

  // Data only needs synchronising: it is stable around the clock fall, and
  // the filtered clock lags the pin by far more than these two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dsync <= 2'b11;
    else        dsync <= {dsync[0], ps2Data};
  end
  assign data = dsync[1];

  // A fall in the same cycle as the timeout wins, since it shows the device is alive.
  assign timeout = (state != ST_IDLE) && !fall && (tocnt == TO_W'(TIMEOUT_CYC - 1));
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    shift_en  = 1'b0;
    pbit_en   = 1'b0;
    start_en  = 1'b0;
    if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!data) begin
            state_nxt = ST_DATA;
            start_en  = 1'b1;
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          if (bitcnt == BW'(PS2_DATA_BITS - 1)) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          pbit_en   = 1'b1;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (data && parity_ok(shreg, pbit)) done_nxt = 1'b1;
          else                                err_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      err_nxt   = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt   <= '0;
      shreg    <= '0;
      pbit     <= 1'b0;
      tocnt    <= '0;
      scanCode <= '0;
      scanDone <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      scanDone <= done_nxt;
      frameErr <= err_nxt;
      if (done_nxt) scanCode <= shreg;
      if (start_en) bitcnt <= '0;
      if (shift_en) begin
        shreg  <= {data, shreg[PS2_DATA_BITS-1:1]};  // LSB arrives first
        bitcnt <= bitcnt + 1'b1;
      end
      if (pbit_en) pbit <= data;
      if (fall || state == ST_IDLE) tocnt <= '0;
      else if (tocnt != {TO_W{1'b1}}) tocnt <= tocnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
module tb_ps2_frame_rx;

  localparam int FL = 8;
  localparam int TO = 300;
  localparam int TW = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       scanDone;
  logic [7:0] scanCode;
  logic       frameErr;
  logic       busy;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .TO_W(TW)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2Clk   (ps2Clk),
    .ps2Data  (ps2Data),
    .scanDone (scanDone),
    .scanCode (scanCode),
    .frameErr (frameErr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;
  always @(posedge clk) cyc_no++;

  typedef struct {
    bit         err;
    logic [7:0] code;
  } exp_t;
  exp_t q[$];

  logic [7:0] model_code = 8'h00;
  int done_seen = 0;
  int err_seen  = 0;
  int err_cyc   = 0;
  int fall_cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Expected outcome of a frame derived directly from its bit list:
  // start 0, 8 data bits LSB first, odd parity over data+parity, stop 1.
  task automatic expect_frame(input logic [10:0] f);
    exp_t e;
    e.err  = !(f[10] == 1'b1 && (^f[9:1]) == 1'b1);
    e.code = f[8:1];
    q.push_back(e);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^d) ^ bad_par;
    return {~bad_stop, p, d, 1'b0};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input int half, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2Data = f[i];
      if (glitch) begin
        cycles(half / 2 - 2);
        ps2Clk = 1'b0;
        cycles(3);
        ps2Clk = 1'b1;
        cycles(half - half / 2 - 1);
      end else begin
        cycles(half);
      end
      ps2Clk   = 1'b0;
      fall_cyc = cyc_no;
      cycles(half);
      ps2Clk = 1'b1;
    end
  endtask

  // Scoreboard: every cycle after the edge, compare pulses and the held code with the model.
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      check("reset_outputs", {scanDone, frameErr, busy, scanCode}, 11'd0);
      model_code = 8'h00;
    end else begin
      if (scanDone && frameErr) check("done_err_exclusive", 1, 0);
      if (scanDone) begin
        done_seen++;
        if (q.size() == 0 || q[0].err) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_code", scanCode, q[0].code);
          model_code = q[0].code;
          void'(q.pop_front());
        end
      end
      if (frameErr) begin
        err_seen++;
        err_cyc = cyc_no;
        if (q.size() == 0 || !q[0].err) check("unexpected_err", 1, 0);
        else void'(q.pop_front());
      end
      check("code_hold", scanCode, model_code);
    end
  end

  task automatic frame_case(input logic [7:0] d, input bit bp, input bit bs, input int half,
                            input bit glitch, input int exp_done, input int exp_err,
                            input logic [7:0] exp_code, input string name);
    logic [10:0] f;
    int d0, e0;
    f  = make_frame(d, bp, bs);
    d0 = done_seen;
    e0 = err_seen;
    expect_frame(f);
    send_bits(f, 11, half, glitch);
    cycles(20);
    check({name, "_done_cnt"}, done_seen - d0, exp_done);
    check({name, "_err_cnt"}, err_seen - e0, exp_err);
    check({name, "_code"}, scanCode, exp_code);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [10:0] f;
    int d0, e0, diff;

    // Reset held with pins toggling.
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ps2Clk  = 1'($urandom_range(0, 1));
      ps2Data = 1'($urandom_range(0, 1));
      cycles(1);
    end
    check("rst_code", scanCode, 8'h00);
    check("rst_pulses", {scanDone, frameErr, busy}, 3'b000);
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    cycles(5);
    reset = 1'b1;
    cycles(20);
    check("idle_busy", busy, 1'b0);

    // 0x1C, checking busy mid-frame.
    f  = make_frame(8'h1C, 0, 0);
    d0 = done_seen;
    e0 = err_seen;
    expect_frame(f);
    send_bits(f, 3, 25, 0);
    check("mid_busy", busy, 1'b1);
    send_bits(f >> 3, 8, 25, 0);
    cycles(20);
    check("f1c_done_cnt", done_seen - d0, 1);
    check("f1c_err_cnt", err_seen - e0, 0);
    check("f1c_code", scanCode, 8'h1C);
    check("f1c_busy", busy, 1'b0);

    frame_case(8'hF0, 0, 0, 25, 0, 1, 0, 8'hF0, "f0_good");
    frame_case(8'hF0, 1, 0, 25, 0, 0, 1, 8'hF0, "f0_badpar");
    frame_case(8'h29, 0, 1, 25, 0, 0, 1, 8'hF0, "f29_badstop");

    // Short low glitches while idle with data low must not start a frame.
    ps2Data = 1'b0;
    d0 = done_seen;
    e0 = err_seen;
    for (int i = 0; i < 5; i++) begin
      ps2Clk = 1'b0;
      cycles(3);
      ps2Clk = 1'b1;
      cycles(10);
      check("glitch_idle_busy", busy, 1'b0);
    end
    cycles(20);
    check("glitch_idle_pulses", (done_seen - d0) + (err_seen - e0), 0);
    ps2Data = 1'b1;
    cycles(10);
    frame_case(8'h1C, 0, 0, 40, 1, 1, 0, 8'h1C, "f1c_glitch");

    // Partial frame followed by silence -> timeout.
    f  = make_frame(8'h33, 0, 0);
    e0 = err_seen;
    begin
      exp_t e;
      e.err  = 1'b1;
      e.code = 8'h00;
      q.push_back(e);
    end
    send_bits(f, 5, 25, 0);
    for (int k = 0; k < TO + 60 && err_seen == e0; k++) cycles(1);
    check("timeout_seen", err_seen - e0, 1);
    diff = err_cyc - fall_cyc;
    total++;
    if (diff < TO + 8 || diff > TO + 14) begin
      bad++;
      $display("FAIL timeout_delay: got %0d cycles expected about %0d", diff, TO + 11);
    end
    cycles(2);
    check("timeout_busy", busy, 1'b0);
    frame_case(8'h5A, 0, 0, 25, 0, 1, 0, 8'h5A, "f5a_after_to");

    // Partial frame cut short by reset: no pulses, then a clean frame.
    send_bits(f, 5, 25, 0);
    d0 = done_seen;
    e0 = err_seen;
    cycles(3);
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(TO + 50);
    check("rst_mid_pulses", (done_seen - d0) + (err_seen - e0), 0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_code", scanCode, 8'h00);
    frame_case(8'h5A, 0, 0, 25, 0, 1, 0, 8'h5A, "f5a_after_rst");

    // Randomized frames, some corrupted, some back-to-back, some with glitches.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      bit bp, bs, gl;
      int half;
      d    = 8'($urandom);
      bp   = ($urandom_range(0, 3) == 0);
      bs   = ($urandom_range(0, 4) == 0);
      half = $urandom_range(20, 45);
      gl   = (half >= 30) && ($urandom_range(0, 1) == 1);
      f    = make_frame(d, bp, bs);
      expect_frame(f);
      send_bits(f, 11, half, gl);
      cycles($urandom_range(0, 30));
    end
    cycles(40);
    check("queue_empty", q.size(), 0);
    check("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
